// File: rtl/instruction_fetch_pkg.sv
// Shared core definitions: default widths, the NOP encoding and the fetch FSM states.
// The branch/signal decoder imports the same package.
package instruction_fetch_pkg;

    localparam int CORE_PC_WIDTH    = 7;
    localparam int CORE_INSTR_WIDTH = 16;

    localparam logic [CORE_INSTR_WIDTH-1:0] NOP = 16'h0000;

    typedef enum logic [0:0] {
        S_PRIME = 1'b0,
        S_RUN   = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_program_counter.sv
// Fetch program counter: holds the address the ROM is reading and selects the next one
// (hold on stall, jump on an accepted branch, otherwise increment with natural wrap).
module instruction_fetch_program_counter #(
    parameter int                  PC_WIDTH     = 7,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(0)
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                i_run,
    input  logic                i_stall,
    input  logic                i_branch,
    input  logic [PC_WIDTH-1:0] i_branch_dir,
    output logic [PC_WIDTH-1:0] o_fetch_pc,
    output logic [PC_WIDTH-1:0] o_next_pc
);

    logic [PC_WIDTH-1:0] r_fetch_pc;
    logic [PC_WIDTH-1:0] w_next_pc;

    // Next-address select; while priming the ROM re-reads the current address.
    always_comb begin
        w_next_pc = r_fetch_pc;
        if (!i_run) begin
            w_next_pc = r_fetch_pc;
        end else if (i_stall) begin
            w_next_pc = r_fetch_pc;
        end else if (i_branch) begin
            w_next_pc = i_branch_dir;
        end else begin
            w_next_pc = r_fetch_pc + PC_WIDTH'(1);
        end
    end

    // PC register tracks the address presented to the ROM every edge.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_fetch_pc <= RESET_VECTOR;
        end else begin
            r_fetch_pc <= w_next_pc;
        end
    end

    assign o_fetch_pc = r_fetch_pc;
    assign o_next_pc  = w_next_pc;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: primes the synchronous ROM after reset, registers one instruction per cycle,
// and turns an accepted branch into a single bubble that squashes the wrong-path word.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int                  PC_WIDTH     = CORE_PC_WIDTH,
    parameter int                  INSTR_WIDTH  = CORE_INSTR_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(0)
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   iStall,
    input  logic                   iBranch_taken,
    input  logic [PC_WIDTH-1:0]    iBranch_dir,
    output logic [PC_WIDTH-1:0]    oRom_addr,
    input  logic [INSTR_WIDTH-1:0] iRom_data,
    output logic [INSTR_WIDTH-1:0] oInstruction,
    output logic                   oInstr_valid,
    output logic [PC_WIDTH-1:0]    oPC
);

    fetch_state_e        r_state;
    fetch_state_e        w_state_next;
    logic                w_run;
    logic                w_branch;
    logic [PC_WIDTH-1:0] w_fetch_pc;

    assign w_run = (r_state == S_RUN);
    // A branch only counts for a real instruction that is not being held.
    assign w_branch = iBranch_taken & oInstr_valid & ~iStall;

    instruction_fetch_program_counter #(
        .PC_WIDTH     (PC_WIDTH),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_program_counter (
        .Clock        (Clock),
        .Reset        (Reset),
        .i_run        (w_run),
        .i_stall      (iStall),
        .i_branch     (w_branch),
        .i_branch_dir (iBranch_dir),
        .o_fetch_pc   (w_fetch_pc),
        .o_next_pc    (oRom_addr)
    );

    // Fetch FSM state register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= S_PRIME;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Fetch FSM next state: one priming cycle, then run until reset.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_PRIME: w_state_next = S_RUN;
            S_RUN:   w_state_next = S_RUN;
            default: w_state_next = S_PRIME;
        endcase
    end

    // Instruction register: hold on stall, bubble on branch, else capture the ROM word.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            oInstruction <= INSTR_WIDTH'(NOP);
            oInstr_valid <= 1'b0;
            oPC          <= PC_WIDTH'(0);
        end else if (!w_run) begin
            oInstruction <= oInstruction;
            oInstr_valid <= oInstr_valid;
            oPC          <= oPC;
        end else if (iStall) begin
            oInstruction <= oInstruction;
            oInstr_valid <= oInstr_valid;
            oPC          <= oPC;
        end else if (w_branch) begin
            oInstruction <= INSTR_WIDTH'(NOP);
            oInstr_valid <= 1'b0;
            oPC          <= PC_WIDTH'(0);
        end else begin
            oInstruction <= iRom_data;
            oInstr_valid <= 1'b1;
            oPC          <= w_fetch_pc;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a ROM model holding 16'h1000+addr, a per-cycle
// vector table for sequential/branch/stall/wrap behaviour, and hand sequences for reset.
module tb_instruction_fetch;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        br_taken;
    logic [6:0]  br_dir;
    logic [6:0]  rom_addr;
    logic [15:0] rom_q;
    logic [15:0] instr;
    logic        valid;
    logic [6:0]  pc;

    int n_checks = 0;
    int n_errors = 0;

    instruction_fetch dut (
        .Clock         (clk),
        .Reset         (rst),
        .iStall        (stall),
        .iBranch_taken (br_taken),
        .iBranch_dir   (br_dir),
        .oRom_addr     (rom_addr),
        .iRom_data     (rom_q),
        .oInstruction  (instr),
        .oInstr_valid  (valid),
        .oPC           (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM model: word at address a is 16'h1000 + a.
    always @(posedge clk) rom_q <= 16'h1000 + {9'd0, rom_addr};

    typedef struct {
        logic       stall;
        logic       br;
        logic [6:0] dir;
        logic [6:0] exp_addr;
        logic       exp_valid;
        logic [6:0] exp_pc;
    } vec_t;

    vec_t vecs [32];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [15:0] exp_word(input logic v, input logic [6:0] p);
        return v ? (16'h1000 + {9'd0, p}) : 16'h0000;
    endfunction

    task automatic set_vec(input int i, input logic s, input logic b, input logic [6:0] d,
                           input logic [6:0] a, input logic v, input logic [6:0] p);
        vecs[i].stall = s; vecs[i].br = b; vecs[i].dir = d;
        vecs[i].exp_addr = a; vecs[i].exp_valid = v; vecs[i].exp_pc = p;
    endtask

    task automatic post_edge_check(input string tag, input logic v, input logic [6:0] p);
        check({tag, " valid"}, {15'd0, valid}, {15'd0, v});
        check({tag, " pc"}, {9'd0, pc}, {9'd0, p});
        check({tag, " instr"}, instr, exp_word(v, p));
    endtask

    initial begin
        // stall, br, dir, exp_addr (before edge), exp_valid/exp_pc (after edge)
        set_vec( 0, 1'b0, 1'b1, 7'd50,  7'd0,   1'b0, 7'd0);   // prime, branch ignored
        set_vec( 1, 1'b0, 1'b0, 7'd0,   7'd1,   1'b1, 7'd0);
        set_vec( 2, 1'b0, 1'b0, 7'd0,   7'd2,   1'b1, 7'd1);
        set_vec( 3, 1'b0, 1'b0, 7'd0,   7'd3,   1'b1, 7'd2);
        set_vec( 4, 1'b0, 1'b0, 7'd0,   7'd4,   1'b1, 7'd3);
        set_vec( 5, 1'b0, 1'b0, 7'd0,   7'd5,   1'b1, 7'd4);
        set_vec( 6, 1'b0, 1'b0, 7'd0,   7'd6,   1'b1, 7'd5);
        set_vec( 7, 1'b0, 1'b1, 7'd40,  7'd40,  1'b0, 7'd0);   // branch at oPC=5
        set_vec( 8, 1'b0, 1'b1, 7'd99,  7'd41,  1'b1, 7'd40);  // branch in bubble ignored
        set_vec( 9, 1'b0, 1'b1, 7'd10,  7'd10,  1'b0, 7'd0);
        set_vec(10, 1'b0, 1'b0, 7'd0,   7'd11,  1'b1, 7'd10);
        set_vec(11, 1'b1, 1'b0, 7'd0,   7'd11,  1'b1, 7'd10);  // stall x3
        set_vec(12, 1'b1, 1'b0, 7'd0,   7'd11,  1'b1, 7'd10);
        set_vec(13, 1'b1, 1'b0, 7'd0,   7'd11,  1'b1, 7'd10);
        set_vec(14, 1'b0, 1'b0, 7'd0,   7'd12,  1'b1, 7'd11);
        set_vec(15, 1'b0, 1'b1, 7'd20,  7'd20,  1'b0, 7'd0);
        set_vec(16, 1'b0, 1'b0, 7'd0,   7'd21,  1'b1, 7'd20);
        set_vec(17, 1'b1, 1'b1, 7'd3,   7'd21,  1'b1, 7'd20);  // stall beats branch
        set_vec(18, 1'b1, 1'b1, 7'd3,   7'd21,  1'b1, 7'd20);
        set_vec(19, 1'b0, 1'b1, 7'd3,   7'd3,   1'b0, 7'd0);
        set_vec(20, 1'b0, 1'b0, 7'd0,   7'd4,   1'b1, 7'd3);
        set_vec(21, 1'b0, 1'b1, 7'd126, 7'd126, 1'b0, 7'd0);
        set_vec(22, 1'b0, 1'b0, 7'd0,   7'd127, 1'b1, 7'd126);
        set_vec(23, 1'b0, 1'b0, 7'd0,   7'd0,   1'b1, 7'd127); // address wrap
        set_vec(24, 1'b0, 1'b0, 7'd0,   7'd1,   1'b1, 7'd0);
        set_vec(25, 1'b0, 1'b1, 7'd1,   7'd1,   1'b0, 7'd0);   // branch to next address
        set_vec(26, 1'b0, 1'b0, 7'd0,   7'd2,   1'b1, 7'd1);
        set_vec(27, 1'b0, 1'b1, 7'd1,   7'd1,   1'b0, 7'd0);   // branch to current address
        set_vec(28, 1'b0, 1'b0, 7'd0,   7'd2,   1'b1, 7'd1);
        set_vec(29, 1'b0, 1'b1, 7'd59,  7'd59,  1'b0, 7'd0);
        set_vec(30, 1'b0, 1'b0, 7'd0,   7'd60,  1'b1, 7'd59);
        set_vec(31, 1'b0, 1'b0, 7'd0,   7'd61,  1'b1, 7'd60);

        rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_dir = 7'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        post_edge_check("reset", 1'b0, 7'd0);
        check("reset addr", {9'd0, rom_addr}, 16'd0);
        rst = 1'b0;

        for (int i = 0; i < 32; i++) begin
            stall = vecs[i].stall; br_taken = vecs[i].br; br_dir = vecs[i].dir;
            #1;
            check($sformatf("v%0d addr", i), {9'd0, rom_addr}, {9'd0, vecs[i].exp_addr});
            @(posedge clk); #1;
            post_edge_check($sformatf("v%0d", i), vecs[i].exp_valid, vecs[i].exp_pc);
            @(negedge clk);
        end

        // Mid-run reset at oPC=60: outputs clear without waiting for a clock edge.
        stall = 1'b0; br_taken = 1'b0;
        #2 rst = 1'b1;
        #1;
        post_edge_check("midrst async", 1'b0, 7'd0);
        check("midrst addr", {9'd0, rom_addr}, 16'd0);
        @(posedge clk); #1;
        post_edge_check("midrst held", 1'b0, 7'd0);
        @(negedge clk);
        rst = 1'b0; br_taken = 1'b1; br_dir = 7'd77;
        #1;
        check("restart prime addr", {9'd0, rom_addr}, 16'd0);
        @(posedge clk); #1;
        post_edge_check("restart prime", 1'b0, 7'd0);
        @(negedge clk);
        br_taken = 1'b0;
        #1;
        check("restart addr", {9'd0, rom_addr}, 16'd1);
        @(posedge clk); #1;
        post_edge_check("restart first", 1'b1, 7'd0);
        @(posedge clk); #1;
        post_edge_check("restart second", 1'b1, 7'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
